// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the execute-stage shifter path: shift-type codes,
// datapath widths and the arbiter sequencer state encoding.
package shift_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int AMT_W  = 5;

  // Shift-type codes as seen by the decoder and the shifter.
  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_RESP  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_arbiter_if.sv
// Request/response handshake bundle between the two shift requesters, the
// result consumer and the shift arbiter.
interface shift_arbiter_if;
  import shift_arbiter_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_data;
  logic [1:0]        req0_type;
  logic [AMT_W-1:0]  req0_amt;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_data;
  logic [1:0]        req1_type;
  logic [AMT_W-1:0]  req1_amt;

  logic              resp_valid;
  logic              resp_ready;
  logic              resp_id;
  logic [DATA_W-1:0] resp_data;

  // Requesters and result consumer side.
  modport master (
    output req0_valid, req0_data, req0_type, req0_amt,
    output req1_valid, req1_data, req1_type, req1_amt,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_data
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req0_data, req0_type, req0_amt,
    input  req1_valid, req1_data, req1_type, req1_amt,
    input  resp_ready,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_data
  );

endinterface

// File: rtl/shift_arbiter_rr_arb2.sv
// Two-requester round-robin grant. The grant is one-hot and combinational;
// last_reg remembers which port won most recently so a tie goes to the other.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // last_reg = 1 means port 1 won last, so port 0 takes the first tie.
  logic last_reg;

  // Pick a winner: a lone requester wins outright, a tie goes away from last_reg.
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = last_reg ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  // Remember the winner, but only when a grant was actually issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_reg <= 1'b1;
    end else if (|gnt) begin
      last_reg <= gnt[1];
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Shares the single operand shifter between the operand-2 path (port 0) and
// the load/store offset path (port 1): grant, latch operands, drive the shifter
// for one cycle, register its result and hand it out tagged with the port ID.
module shift_arbiter
  import shift_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  shift_arbiter_if.slave    bus,
  output logic [DATA_W-1:0] sh_rmData,
  output logic [1:0]        sh_shiftType,
  output logic [AMT_W-1:0]  sh_rm_shift,
  input  logic [DATA_W-1:0] sh_result
);

  state_t            state_reg;
  state_t            state_next;
  logic              accept_en;
  logic [1:0]        gnt;

  logic [DATA_W-1:0] op_data_reg;
  logic [1:0]        op_type_reg;
  logic [AMT_W-1:0]  op_amt_reg;
  logic              id_reg;

  logic              resp_valid_reg;
  logic              resp_id_reg;
  logic [DATA_W-1:0] resp_data_reg;

  // A new request may be taken when idle, or when the pending result is
  // leaving this very cycle; never while reset is held.
  assign accept_en = !reset &&
                     ((state_reg == ST_IDLE) ||
                      ((state_reg == ST_RESP) && bus.resp_ready));

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({bus.req1_valid, bus.req0_valid}),
    .en    (accept_en),
    .gnt   (gnt)
  );

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];

  // The shifter sees the latched operands; they hold between requests.
  assign sh_rmData    = op_data_reg;
  assign sh_shiftType = op_type_reg;
  assign sh_rm_shift  = op_amt_reg;

  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_id    = resp_id_reg;
  assign bus.resp_data  = resp_data_reg;

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: one cycle in SHIFT, then wait in RESP for the consumer.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|gnt) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        state_next = ST_RESP;
      end
      ST_RESP: begin
        if (bus.resp_ready) state_next = (|gnt) ? ST_SHIFT : ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Latch the winner's operands on grant; capture the shifter output in SHIFT.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_data_reg    <= '0;
      op_type_reg    <= '0;
      op_amt_reg     <= '0;
      id_reg         <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_id_reg    <= 1'b0;
      resp_data_reg  <= '0;
    end else begin
      if (|gnt) begin
        op_data_reg <= gnt[1] ? bus.req1_data : bus.req0_data;
        op_type_reg <= gnt[1] ? bus.req1_type : bus.req0_type;
        op_amt_reg  <= gnt[1] ? bus.req1_amt  : bus.req0_amt;
        id_reg      <= gnt[1];
      end
      if (state_reg == ST_SHIFT) begin
        resp_data_reg  <= sh_result;
        resp_id_reg    <= id_reg;
        resp_valid_reg <= 1'b1;
      end else if ((state_reg == ST_RESP) && bus.resp_ready) begin
        resp_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: a behavioural shifter stands in for the real one,
// and expected grants/results come from the arbitration and shift rules.
module tb_shift_arbiter;
  import shift_arbiter_pkg::*;

  logic        clk;
  logic        reset;
  logic [31:0] sh_rmData;
  logic [1:0]  sh_shiftType;
  logic [4:0]  sh_rm_shift;
  logic [31:0] sh_result;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  logic model_last;  // 1 = port 1 won most recently

  shift_arbiter_if bus ();

  shift_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .sh_rmData    (sh_rmData),
    .sh_shiftType (sh_shiftType),
    .sh_rm_shift  (sh_rm_shift),
    .sh_result    (sh_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [1:0] t,
                                            input logic [4:0] a);
    logic [63:0] dd;
    dd = {d, d} >> a;
    case (t)
      2'b00:   return d << a;
      2'b01:   return d >> a;
      2'b10:   return 32'($signed(d) >>> a);
      default: return dd[31:0];
    endcase
  endfunction

  // Stand-in for the execute-stage shifter.
  always_comb sh_result = ref_shift(sh_rmData, sh_shiftType, sh_rm_shift);

  task automatic drive_port(input int p, input logic v, input logic [31:0] d,
                            input logic [1:0] t, input logic [4:0] a);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_data = d; bus.req0_type = t; bus.req0_amt = a;
    end else begin
      bus.req1_valid = v; bus.req1_data = d; bus.req1_type = t; bus.req1_amt = a;
    end
  endtask

  // One isolated request on port p with resp_ready held high; returns what was seen.
  task automatic run_single(input int p, input logic [31:0] d, input logic [1:0] t,
                            input logic [4:0] a, output logic rdy, output logic other_rdy,
                            output int lat, output logic [31:0] rdata, output logic rid);
    bus.resp_ready = 1'b1;
    drive_port(p, 1'b1, d, t, a);
    @(negedge clk);
    rdy       = (p == 0) ? bus.req0_ready : bus.req1_ready;
    other_rdy = (p == 0) ? bus.req1_ready : bus.req0_ready;
    @(posedge clk); #1;
    drive_port(p, 1'b0, 32'h0, 2'b00, 5'd0);
    model_last = (p != 0);
    lat = 0;
    rdata = 32'h0;
    rid = 1'b0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (bus.resp_valid) break;
    end
    rdata = bus.resp_data;
    rid   = bus.resp_id;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.resp_ready = 1'b1;
    drive_port(0, 1'b1, $urandom, 2'($urandom), 5'($urandom));
    drive_port(1, 1'b1, $urandom, 2'($urandom), 5'($urandom));
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    assert_cnt++; if (bus.resp_valid !== 1'b0) begin fail_cnt++; $display("FAIL reset_resp_valid: got %0b want 0", bus.resp_valid); end
    assert_cnt++; if (bus.resp_id !== 1'b0) begin fail_cnt++; $display("FAIL reset_resp_id: got %0b want 0", bus.resp_id); end
    assert_cnt++; if (bus.resp_data !== 32'h0) begin fail_cnt++; $display("FAIL reset_resp_data: got %h want 0", bus.resp_data); end
    assert_cnt++; if (sh_rmData !== 32'h0 || sh_shiftType !== 2'b00 || sh_rm_shift !== 5'd0) begin fail_cnt++; $display("FAIL reset_sh: got %h/%0d/%0d want 0/0/0", sh_rmData, sh_shiftType, sh_rm_shift); end
    assert_cnt++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin fail_cnt++; $display("FAIL reset_ready: got %0b%0b want 00", bus.req1_ready, bus.req0_ready); end
    $display("reset: outputs checked with reset held");
    @(posedge clk); #1;
    reset = 1'b0;
    drive_port(0, 1'b0, 32'h0, 2'b00, 5'd0);
    drive_port(1, 1'b0, 32'h0, 2'b00, 5'd0);
    model_last = 1'b1;
  endtask

  task automatic test_single;
    logic rdy, other; int lat; logic [31:0] rdata; logic rid;
    run_single(0, 32'h1, SH_LSL, 5'd4, rdy, other, lat, rdata, rid);
    $display("single: port0 LSL 1 by 4 -> %h id %0d lat %0d", rdata, rid, lat);
    assert_cnt++; if (rdy !== 1'b1) begin fail_cnt++; $display("FAIL single_ready: got %0b want 1", rdy); end
    assert_cnt++; if (other !== 1'b0) begin fail_cnt++; $display("FAIL single_other_ready: got %0b want 0", other); end
    assert_cnt++; if (lat != 2) begin fail_cnt++; $display("FAIL single_latency: got %0d want 2", lat); end
    assert_cnt++; if (rdata !== 32'h10) begin fail_cnt++; $display("FAIL single_data: got %h want 00000010", rdata); end
    assert_cnt++; if (rid !== 1'b0) begin fail_cnt++; $display("FAIL single_id: got %0b want 0", rid); end
  endtask

  task automatic test_asr_ror;
    logic rdy, other; int lat; logic [31:0] rdata; logic rid;
    run_single(1, 32'h8000_0000, SH_ASR, 5'd4, rdy, other, lat, rdata, rid);
    $display("asr: port1 80000000 by 4 -> %h id %0d", rdata, rid);
    assert_cnt++; if (rdy !== 1'b1 || other !== 1'b0) begin fail_cnt++; $display("FAIL asr_ready: got %0b/%0b want 1/0", rdy, other); end
    assert_cnt++; if (rdata !== 32'hF800_0000) begin fail_cnt++; $display("FAIL asr_data: got %h want f8000000", rdata); end
    assert_cnt++; if (rid !== 1'b1) begin fail_cnt++; $display("FAIL asr_id: got %0b want 1", rid); end
    run_single(0, 32'h0000_000F, SH_ROR, 5'd4, rdy, other, lat, rdata, rid);
    $display("ror: port0 0000000f by 4 -> %h id %0d", rdata, rid);
    assert_cnt++; if (rdata !== 32'hF000_0000) begin fail_cnt++; $display("FAIL ror_data: got %h want f0000000", rdata); end
    assert_cnt++; if (rid !== 1'b0) begin fail_cnt++; $display("FAIL ror_id: got %0b want 0", rid); end
  endtask

  task automatic test_amount_zero;
    logic rdy, other; int lat; logic [31:0] rdata; logic rid; int p;
    for (int t = 0; t < 4; t++) begin
      p = int'($urandom_range(0, 1));
      run_single(p, 32'hDEAD_BEEF, 2'(t), 5'd0, rdy, other, lat, rdata, rid);
      $display("amt0: port%0d type %0d -> %h id %0d", p, t, rdata, rid);
      assert_cnt++; if (rdata !== 32'hDEAD_BEEF) begin fail_cnt++; $display("FAIL amt0_data type %0d: got %h want deadbeef", t, rdata); end
      assert_cnt++; if (rid !== 1'(p)) begin fail_cnt++; $display("FAIL amt0_id type %0d: got %0b want %0d", t, rid, p); end
    end
  endtask

  task automatic test_random;
    logic rdy, other; int lat; logic [31:0] rdata; logic rid;
    int p; logic [31:0] d; logic [1:0] t; logic [4:0] a; logic [31:0] exp;
    for (int i = 0; i < 24; i++) begin
      p = int'($urandom_range(0, 1));
      d = $urandom;
      t = 2'($urandom);
      a = 5'($urandom);
      exp = ref_shift(d, t, a);
      run_single(p, d, t, a, rdy, other, lat, rdata, rid);
      $display("random %0d: port%0d %h type %0d amt %0d -> %h (want %h) id %0d", i, p, d, t, a, rdata, exp, rid);
      assert_cnt++; if (rdy !== 1'b1 || other !== 1'b0 || lat != 2) begin fail_cnt++; $display("FAIL random_handshake %0d: ready %0b other %0b lat %0d want 1/0/2", i, rdy, other, lat); end
      assert_cnt++; if (rdata !== exp) begin fail_cnt++; $display("FAIL random_data %0d: got %h want %h", i, rdata, exp); end
      assert_cnt++; if (rid !== 1'(p)) begin fail_cnt++; $display("FAIL random_id %0d: got %0b want %0d", i, rid, p); end
    end
  endtask

  task automatic test_contention;
    logic [31:0] cd [2]; logic [1:0] ct [2]; logic [4:0] ca [2];
    logic        exp_id_q [$];
    logic [31:0] exp_data_q [$];
    logic g0, g1; int gp, exp_gp, prev_g, last_resp_c, ngrants, nresp;
    logic eid; logic [31:0] edata;
    prev_g = -1; last_resp_c = -1; ngrants = 0; nresp = 0;
    bus.resp_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      cd[p] = $urandom; ct[p] = 2'($urandom); ca[p] = 5'($urandom);
      drive_port(p, 1'b1, cd[p], ct[p], ca[p]);
    end
    for (int c = 0; c < 26; c++) begin
      // Both ports stay valid during the first 20 cycles, then the pipe drains.
      @(negedge clk);
      g0 = bus.req0_ready;
      g1 = bus.req1_ready;
      assert_cnt++; if (g0 && g1) begin fail_cnt++; $display("FAIL contention_both_ready cycle %0d: got 11 want at most one", c); end
      gp = -1;
      if (g0 || g1) begin
        gp = g1 ? 1 : 0;
        exp_gp = (c < 20) ? (model_last ? 0 : 1) : -1;
        $display("contention cycle %0d: grant port%0d", c, gp);
        assert_cnt++; if (gp != exp_gp) begin fail_cnt++; $display("FAIL contention_grant cycle %0d: got %0d want %0d", c, gp, exp_gp); end
        if (prev_g >= 0) begin
          assert_cnt++; if (gp == prev_g) begin fail_cnt++; $display("FAIL contention_alternate cycle %0d: got %0d want %0d", c, gp, 1 - prev_g); end
        end
        model_last = (gp != 0);
        exp_id_q.push_back(1'(gp));
        exp_data_q.push_back(ref_shift(cd[gp], ct[gp], ca[gp]));
        prev_g = gp;
        ngrants++;
      end
      if (bus.resp_valid) begin
        nresp++;
        assert_cnt++;
        if (exp_id_q.size() == 0) begin
          fail_cnt++; $display("FAIL contention_resp cycle %0d: got id %0b data %h want no response", c, bus.resp_id, bus.resp_data);
        end else begin
          eid = exp_id_q.pop_front();
          edata = exp_data_q.pop_front();
          $display("contention cycle %0d: resp id %0d data %h", c, bus.resp_id, bus.resp_data);
          if (bus.resp_id !== eid || bus.resp_data !== edata) begin fail_cnt++; $display("FAIL contention_resp cycle %0d: got id %0b data %h want id %0b data %h", c, bus.resp_id, bus.resp_data, eid, edata); end
        end
        if (last_resp_c >= 0) begin
          assert_cnt++; if (c - last_resp_c != 2) begin fail_cnt++; $display("FAIL contention_interval cycle %0d: got %0d want 2", c, c - last_resp_c); end
        end
        last_resp_c = c;
      end
      @(posedge clk); #1;
      if (gp >= 0) begin
        cd[gp] = $urandom; ct[gp] = 2'($urandom); ca[gp] = 5'($urandom);
        drive_port(gp, 1'b1, cd[gp], ct[gp], ca[gp]);
      end
      if (c == 19) begin
        drive_port(0, 1'b0, 32'h0, 2'b00, 5'd0);
        drive_port(1, 1'b0, 32'h0, 2'b00, 5'd0);
      end
    end
    assert_cnt++; if (ngrants != 10 || nresp != 10) begin fail_cnt++; $display("FAIL contention_counts: got %0d grants %0d resps want 10/10", ngrants, nresp); end
    assert_cnt++; if (exp_id_q.size() != 0) begin fail_cnt++; $display("FAIL contention_drain: got %0d outstanding want 0", exp_id_q.size()); end
  endtask

  task automatic test_backpressure;
    logic [31:0] d0, d1, e0, e1; logic [1:0] t0, t1; logic [4:0] a0, a1;
    d0 = $urandom; t0 = 2'($urandom); a0 = 5'($urandom); e0 = ref_shift(d0, t0, a0);
    d1 = $urandom; t1 = 2'($urandom); a1 = 5'($urandom); e1 = ref_shift(d1, t1, a1);
    bus.resp_ready = 1'b0;
    drive_port(0, 1'b1, d0, t0, a0);
    @(negedge clk);
    assert_cnt++; if (bus.req0_ready !== 1'b1) begin fail_cnt++; $display("FAIL bp_accept0: got %0b want 1", bus.req0_ready); end
    @(posedge clk); #1;
    model_last = 1'b0;
    drive_port(0, 1'b0, 32'h0, 2'b00, 5'd0);
    drive_port(1, 1'b1, d1, t1, a1);
    @(negedge clk);
    assert_cnt++; if (bus.req1_ready !== 1'b0) begin fail_cnt++; $display("FAIL bp_shift_ready: got %0b want 0", bus.req1_ready); end
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      $display("backpressure stall %0d: valid %0b id %0d data %h", k, bus.resp_valid, bus.resp_id, bus.resp_data);
      assert_cnt++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b0 || bus.resp_data !== e0) begin fail_cnt++; $display("FAIL bp_hold %0d: got %0b/%0b/%h want 1/0/%h", k, bus.resp_valid, bus.resp_id, bus.resp_data, e0); end
      assert_cnt++; if (bus.req1_ready !== 1'b0) begin fail_cnt++; $display("FAIL bp_stall_ready %0d: got %0b want 0", k, bus.req1_ready); end
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    assert_cnt++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin fail_cnt++; $display("FAIL bp_release_ready: got %0b%0b want 10", bus.req1_ready, bus.req0_ready); end
    @(posedge clk); #1;
    model_last = 1'b1;
    drive_port(1, 1'b0, 32'h0, 2'b00, 5'd0);
    @(negedge clk);
    assert_cnt++; if (bus.resp_valid !== 1'b0) begin fail_cnt++; $display("FAIL bp_shift_valid: got %0b want 0", bus.resp_valid); end
    @(posedge clk); #1;
    @(negedge clk);
    $display("backpressure: port1 resp id %0d data %h", bus.resp_id, bus.resp_data);
    assert_cnt++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b1 || bus.resp_data !== e1) begin fail_cnt++; $display("FAIL bp_resp1: got %0b/%0b/%h want 1/1/%h", bus.resp_valid, bus.resp_id, bus.resp_data, e1); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    logic [31:0] cd [2]; logic [1:0] ct [2]; logic [4:0] ca [2]; int exp_first;
    bus.resp_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      cd[p] = $urandom; ct[p] = 2'($urandom); ca[p] = 5'($urandom);
      drive_port(p, 1'b1, cd[p], ct[p], ca[p]);
    end
    exp_first = model_last ? 0 : 1;
    @(negedge clk);
    assert_cnt++; if (((exp_first == 0) ? bus.req0_ready : bus.req1_ready) !== 1'b1) begin fail_cnt++; $display("FAIL rstmid_pre_grant: got %0b%0b want port%0d", bus.req1_ready, bus.req0_ready, exp_first); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_last = 1'b1;
    @(negedge clk);
    $display("reset mid-shift: valid %0b ready %0b%0b", bus.resp_valid, bus.req1_ready, bus.req0_ready);
    assert_cnt++; if (bus.resp_valid !== 1'b0 || bus.resp_data !== 32'h0 || sh_rmData !== 32'h0) begin fail_cnt++; $display("FAIL rstmid_cleared: got %0b/%h/%h want 0/0/0", bus.resp_valid, bus.resp_data, sh_rmData); end
    assert_cnt++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin fail_cnt++; $display("FAIL rstmid_tie_grant: got %0b%0b want 01", bus.req1_ready, bus.req0_ready); end
    @(posedge clk); #1;
    model_last = 1'b0;
    drive_port(0, 1'b0, 32'h0, 2'b00, 5'd0);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    assert_cnt++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b0 || bus.resp_data !== ref_shift(cd[0], ct[0], ca[0])) begin fail_cnt++; $display("FAIL rstmid_resp0: got %0b/%0b/%h want 1/0/%h", bus.resp_valid, bus.resp_id, bus.resp_data, ref_shift(cd[0], ct[0], ca[0])); end
    assert_cnt++; if (bus.req1_ready !== 1'b1) begin fail_cnt++; $display("FAIL rstmid_same_edge_grant: got %0b want 1", bus.req1_ready); end
    @(posedge clk); #1;
    model_last = 1'b1;
    drive_port(1, 1'b0, 32'h0, 2'b00, 5'd0);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    $display("reset mid-shift: follow-up resp id %0d data %h", bus.resp_id, bus.resp_data);
    assert_cnt++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b1 || bus.resp_data !== ref_shift(cd[1], ct[1], ca[1])) begin fail_cnt++; $display("FAIL rstmid_resp1: got %0b/%0b/%h want 1/1/%h", bus.resp_valid, bus.resp_id, bus.resp_data, ref_shift(cd[1], ct[1], ca[1])); end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    model_last = 1'b1;
    bus.resp_ready = 1'b0;
    drive_port(0, 1'b0, 32'h0, 2'b00, 5'd0);
    drive_port(1, 1'b0, 32'h0, 2'b00, 5'd0);
    test_reset;
    test_single;
    test_asr_ror;
    test_amount_zero;
    test_random;
    test_contention;
    test_backpressure;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
